// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// sram_port_arbiter : two-port round-robin arbiter / sequencer for a
//                     single-port SRAM, with timed ownership lock
// Revision 1.0
// ============================================================================
module sram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LOCK_MAX   = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  r0_req_i,
    input  logic                  r0_lock_i,
    input  logic                  r0_we_i,
    input  logic [ADDR_WIDTH-1:0] r0_addr_i,
    input  logic [DATA_WIDTH-1:0] r0_wdata_i,
    input  logic                  r1_req_i,
    input  logic                  r1_lock_i,
    input  logic                  r1_we_i,
    input  logic [ADDR_WIDTH-1:0] r1_addr_i,
    input  logic [DATA_WIDTH-1:0] r1_wdata_i,
    output logic                  r0_gnt_o,
    output logic                  r1_gnt_o,
    output logic                  r0_rvalid_o,
    output logic                  r1_rvalid_o,
    output logic [DATA_WIDTH-1:0] r0_rdata_o,
    output logic [DATA_WIDTH-1:0] r1_rdata_o,
    output logic                  cs_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] address_o,
    output logic [DATA_WIDTH-1:0] data_out_o,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    output logic                  lock_break_o
);

    localparam logic [1:0] ST_FREE    = 2'd0;
    localparam logic [1:0] ST_LOCKED0 = 2'd1;
    localparam logic [1:0] ST_LOCKED1 = 2'd2;
    localparam logic [7:0] CNT_LAST   = 8'(LOCK_MAX - 1);

    logic [1:0]            state_q, state_d;
    logic                  last_gnt_q, last_gnt_d;
    logic [7:0]            lock_cnt_q, lock_cnt_d;
    logic                  lock_break_q, lock_break_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic                  port_q, port_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  r0_rvalid_q, r0_rvalid_d;
    logic                  r1_rvalid_q, r1_rvalid_d;
    logic [DATA_WIDTH-1:0] r0_rdata_q, r0_rdata_d;
    logic [DATA_WIDTH-1:0] r1_rdata_q, r1_rdata_d;

    logic grant0, grant1;
    logic owner, own_lock, other_req, timeout;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FREE;
            last_gnt_q   <= 1'b1;
            lock_cnt_q   <= 8'd0;
            lock_break_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            lock_cnt_q   <= lock_cnt_d;
            lock_break_q <= lock_break_d;
        end
    end

    assign owner     = (state_q == ST_LOCKED1);
    assign own_lock  = owner ? r1_lock_i : r0_lock_i;
    assign other_req = owner ? r0_req_i : r1_req_i;
    assign timeout   = (state_q != ST_FREE) && own_lock && other_req
                       && (lock_cnt_q == CNT_LAST);

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        last_gnt_d   = last_gnt_q;
        lock_break_d = 1'b0;
        case (state_q)
            ST_FREE: begin
                if (grant0 && r0_lock_i) begin
                    state_d    = ST_LOCKED0;
                    lock_cnt_d = 8'd0;
                end else if (grant1 && r1_lock_i) begin
                    state_d    = ST_LOCKED1;
                    lock_cnt_d = 8'd0;
                end
            end
            ST_LOCKED0, ST_LOCKED1: begin
                if (!own_lock) begin
                    state_d = ST_FREE;
                end else if (timeout) begin
                    state_d      = ST_FREE;
                    lock_break_d = 1'b1;
                end else if (other_req) begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_FREE;
        endcase
        if (grant0) begin
            last_gnt_d = 1'b0;
        end else if (grant1) begin
            last_gnt_d = 1'b1;
        end
        // Forced release hands the next tie to the waiting side.
        if (timeout) begin
            last_gnt_d = owner;
        end
    end

    // Output (grant) logic; last_gnt_q=1 means r1 was served last, so r0 wins a tie
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FREE: begin
                    if (r0_req_i && r1_req_i) begin
                        grant0 = last_gnt_q;
                        grant1 = !last_gnt_q;
                    end else begin
                        grant0 = r0_req_i;
                        grant1 = r1_req_i;
                    end
                end
                ST_LOCKED0: grant0 = r0_req_i;
                ST_LOCKED1: grant1 = r1_req_i;
                default: ;
            endcase
        end
    end

    // Command stage and read-return stage
    always_comb begin
        cs_d        = grant0 | grant1;
        port_d      = grant1;
        we_d        = 1'b0;
        address_d   = address_q;
        data_out_d  = data_out_q;
        if (grant0 | grant1) begin
            we_d       = grant1 ? r1_we_i : r0_we_i;
            address_d  = grant1 ? r1_addr_i : r0_addr_i;
            data_out_d = we_d ? (grant1 ? r1_wdata_i : r0_wdata_i) : '0;
        end
        r0_rvalid_d = cs_q && !we_q && !port_q;
        r1_rvalid_d = cs_q && !we_q && port_q;
        r0_rdata_d  = r0_rvalid_d ? data_in_i : r0_rdata_q;
        r1_rdata_d  = r1_rvalid_d ? data_in_i : r1_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            port_q      <= 1'b0;
            address_q   <= '0;
            data_out_q  <= '0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            r0_rdata_q  <= '0;
            r1_rdata_q  <= '0;
        end else begin
            cs_q        <= cs_d;
            we_q        <= we_d;
            port_q      <= port_d;
            address_q   <= address_d;
            data_out_q  <= data_out_d;
            r0_rvalid_q <= r0_rvalid_d;
            r1_rvalid_q <= r1_rvalid_d;
            r0_rdata_q  <= r0_rdata_d;
            r1_rdata_q  <= r1_rdata_d;
        end
    end

    assign r0_gnt_o     = grant0;
    assign r1_gnt_o     = grant1;
    assign r0_rvalid_o  = r0_rvalid_q;
    assign r1_rvalid_o  = r1_rvalid_q;
    assign r0_rdata_o   = r0_rdata_q;
    assign r1_rdata_o   = r1_rdata_q;
    assign cs_o         = cs_q;
    assign we_o         = we_q;
    assign address_o    = address_q;
    assign data_out_o   = data_out_q;
    assign lock_break_o = lock_break_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sram_port_arbiter : randomized bench for sram_port_arbiter with an SRAM
//                        model and a transaction-level reference model
// Revision 1.0
// ============================================================================
module tb_sram_port_arbiter;

    localparam int LOCK_MAX = 4;

    typedef struct packed {
        logic       lk;
        logic       we;
        logic [7:0] a;
        logic [7:0] d;
    } txn_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       r0_req, r0_lock, r0_we, r1_req, r1_lock, r1_we;
    logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic       r0_gnt_o, r1_gnt_o, r0_rvalid_o, r1_rvalid_o;
    logic [7:0] r0_rdata_o, r1_rdata_o;
    logic       cs_o, we_o, lock_break_o;
    logic [7:0] address_o, data_out_o, sram_q;

    sram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .r0_req_i(r0_req), .r0_lock_i(r0_lock), .r0_we_i(r0_we),
        .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata),
        .r1_req_i(r1_req), .r1_lock_i(r1_lock), .r1_we_i(r1_we),
        .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata),
        .r0_gnt_o(r0_gnt_o), .r1_gnt_o(r1_gnt_o),
        .r0_rvalid_o(r0_rvalid_o), .r1_rvalid_o(r1_rvalid_o),
        .r0_rdata_o(r0_rdata_o), .r1_rdata_o(r1_rdata_o),
        .cs_o(cs_o), .we_o(we_o), .address_o(address_o), .data_out_o(data_out_o),
        .data_in_i(sram_q), .lock_break_o(lock_break_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        return (i == 5) ? 8'hEE : 8'((i * 7 + 3) % 256);
    endfunction

    // SRAM: combinational read, write on a cs/we cycle
    logic [7:0] mem [256];
    bit         mem_ready;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (cs_o && we_o) begin
            mem[address_o] <= data_out_o;
        end
    end
    assign sram_q = mem[address_o];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: ownership, round-robin memory, SRAM contents, and a
    // small time-indexed schedule of read returns.
    logic [7:0] ref_mem [256];
    int         lock_own, last, wcnt, cyc, m_g, brk_seen;
    bit         model_ok;
    logic       e_cs, e_we, e_brk;
    logic [7:0] e_addr, e_dout;
    logic       e_rv [2];
    logic [7:0] e_rd [2];
    logic       sv [4][2];
    logic [7:0] sd [4][2];

    txn_t       q0[$], q1[$];
    logic [1:0] idle_lock;

    task automatic model_reset();
        lock_own = -1; last = 1; wcnt = 0;
        e_cs = 0; e_we = 0; e_brk = 0; e_addr = 0; e_dout = 0;
        for (int p = 0; p < 2; p++) begin
            e_rv[p] = 0; e_rd[p] = 0;
            for (int s = 0; s < 4; s++) sv[s][p] = 0;
        end
    endtask

    task automatic model_step();
        logic [1:0] rq, lk;
        txn_t       t;
        int         n;
        bit         was_locked;
        rq = {r1_req, r0_req};
        lk = {r1_lock, r0_lock};
        if (lock_break_o) brk_seen++;
        if (model_ok) begin
            chk("cs", 32'(cs_o), 32'(e_cs));
            chk("we", 32'(we_o), 32'(e_we));
            chk("address", 32'(address_o), 32'(e_addr));
            chk("data_out", 32'(data_out_o), 32'(e_dout));
            chk("r0_rvalid", 32'(r0_rvalid_o), 32'(e_rv[0]));
            chk("r1_rvalid", 32'(r1_rvalid_o), 32'(e_rv[1]));
            chk("r0_rdata", 32'(r0_rdata_o), 32'(e_rd[0]));
            chk("r1_rdata", 32'(r1_rdata_o), 32'(e_rd[1]));
            chk("lock_break", 32'(lock_break_o), 32'(e_brk));
        end
        m_g = -1;
        if (!reset) begin
            if (lock_own >= 0) begin
                if (rq[lock_own]) m_g = lock_own;
            end else if (rq == 2'b11) m_g = 1 - last;
            else if (rq[0]) m_g = 0;
            else if (rq[1]) m_g = 1;
        end
        chk("r0_gnt", 32'(r0_gnt_o), 32'(m_g == 0));
        chk("r1_gnt", 32'(r1_gnt_o), 32'(m_g == 1));
        if (reset) begin
            model_reset();
            model_ok = 1;
        end else begin
            e_brk = 0;
            was_locked = (lock_own >= 0);
            n = lock_own;
            if (was_locked) begin
                if (!lk[n]) lock_own = -1;
                else if (rq[1-n]) begin
                    if (wcnt == LOCK_MAX - 1) begin
                        lock_own = -1; e_brk = 1; last = n;
                    end else wcnt++;
                end
            end
            e_cs = (m_g >= 0);
            e_we = 0;
            if (m_g >= 0) begin
                t = (m_g == 0) ? txn_t'{r0_lock, r0_we, r0_addr, r0_wdata}
                               : txn_t'{r1_lock, r1_we, r1_addr, r1_wdata};
                last = m_g;
                if (!was_locked && t.lk) begin lock_own = m_g; wcnt = 0; end
                e_we = t.we; e_addr = t.a; e_dout = t.we ? t.d : 8'h00;
                if (t.we) ref_mem[t.a] = t.d;
                else begin
                    sv[(cyc+2)%4][m_g] = 1;
                    sd[(cyc+2)%4][m_g] = ref_mem[t.a];
                end
            end
            for (int p = 0; p < 2; p++) begin
                e_rv[p] = sv[(cyc+1)%4][p];
                if (e_rv[p]) e_rd[p] = sd[(cyc+1)%4][p];
                sv[(cyc+1)%4][p] = 0;
            end
        end
        cyc++;
    endtask

    task automatic apply_inputs();
        r0_req = (q0.size() > 0);
        r1_req = (q1.size() > 0);
        if (r0_req) {r0_lock, r0_we, r0_addr, r0_wdata} = q0[0];
        else r0_lock = idle_lock[0];
        if (r1_req) {r1_lock, r1_we, r1_addr, r1_wdata} = q1[0];
        else r1_lock = idle_lock[1];
    endtask

    task automatic tick();
        apply_inputs();
        @(negedge clk);
        model_step();
        if (m_g == 0) void'(q0.pop_front());
        if (m_g == 1) void'(q1.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int limit);
        int k = 0;
        while ((q0.size() > 0 || q1.size() > 0) && k < limit) begin
            tick();
            k++;
        end
        chk("drain", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.lk = ($urandom_range(0, 99) < 25);
        t.we = $urandom_range(0, 1) == 1;
        t.a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
        t.d  = 8'($urandom);
        return t;
    endfunction

    initial begin
        int b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        model_reset();
        model_ok = 0; cyc = 0; brk_seen = 0; idle_lock = 2'b00;
        r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_we = 0; r1_addr = 0; r1_wdata = 0;
        do_reset();

        // Single read of SRAM[5]
        q0.push_back(txn_t'{1'b0, 1'b0, 8'h05, 8'h00});
        repeat (4) tick();
        chk("single_rdata", 32'(r0_rdata_o), 32'hEE);

        // Round-robin from reset: r0 should win the first tie
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(txn_t'{1'b0, 1'b0, 8'(8'h10 + i), 8'h00});
            q1.push_back(txn_t'{1'b0, 1'b0, 8'(8'h20 + i), 8'h00});
        end
        drain(20);
        repeat (3) tick();

        // Locked write burst with r1 waiting
        for (int i = 0; i < 4; i++)
            q0.push_back(txn_t'{(i != 3), 1'b1, 8'(8'h80 + i), 8'($urandom)});
        tick();
        q1.push_back(txn_t'{1'b0, 1'b0, 8'h82, 8'h00});
        drain(20);
        repeat (3) tick();

        // Lock held past LOCK_MAX waiting cycles
        b0 = brk_seen;
        for (int i = 0; i < 10; i++)
            q0.push_back(txn_t'{(i != 9), 1'b0, 8'(8'h40 + i), 8'h00});
        tick();
        q1.push_back(txn_t'{1'b0, 1'b0, 8'h22, 8'h00});
        drain(40);
        repeat (3) tick();
        chk("break_count", 32'(brk_seen - b0), 32'd1);

        // Write then read back on r1
        q1.push_back(txn_t'{1'b0, 1'b1, 8'h3C, 8'h00});
        q1.push_back(txn_t'{1'b0, 1'b0, 8'h3C, 8'h00});
        drain(10);
        repeat (3) tick();
        chk("wr_rd_data", 32'(r1_rdata_o), 32'h00);

        // Reset while a read is on the SRAM pins
        q0.push_back(txn_t'{1'b0, 1'b0, 8'h11, 8'h00});
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_cs", 32'(cs_o), 32'd0);
        tick();
        chk("rst_rvalid", 32'(r0_rvalid_o), 32'd0);
        repeat (2) tick();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (q0.size() == 0 && $urandom_range(0, 99) < 60) q0.push_back(rand_txn());
            if (q1.size() == 0 && $urandom_range(0, 99) < 60) q1.push_back(rand_txn());
            idle_lock = 2'($urandom);
            tick();
        end
        idle_lock = 2'b00;
        drain(50);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter and sequencer for the single-port 256x8 map SRAM shared by the host map loader (requester 0) and the maze router engine (requester 1). It accepts at most one access per cycle and registers it onto the SRAM pins. It returns read data with fixed latency and supports a lock so one side can own the SRAM for a burst (map load, backtrace write-back). A lock timeout prevents indefinite starvation.

## Interface
- DATA_WIDTH, 8, SRAM word width
- ADDR_WIDTH, 8, SRAM address width
- LOCK_MAX, 64, max cycles a lock is honoured while the other requester waits (>=1, counter 8 bits)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- r0_req, r1_req  in  1  access request
- r0_lock, r1_lock  in  1  keep ownership after this access
- r0_we, r1_we  in  1  1 = write, 0 = read
- r0_addr, r1_addr  in  ADDR_WIDTH  access address
- r0_wdata, r1_wdata  in  DATA_WIDTH  write data
- r0_gnt, r1_gnt  out  1  combinational; request accepted this cycle
- r0_rvalid, r1_rvalid  out  1  read data valid, one-cycle pulse
- r0_rdata, r1_rdata  out  DATA_WIDTH  read data, held until next rvalid for that port
- cs  out  1  SRAM chip select
- we  out  1  SRAM write enable
- address  out  ADDR_WIDTH  SRAM address
- data_out  out  DATA_WIDTH  SRAM write data
- data_in  in  DATA_WIDTH  SRAM read data, combinational from address
- lock_break  out  1  one-cycle pulse when a lock is force-released

## Operation
- State: lock_valid, lock_owner, last_gnt (1 bit), lock_cnt (8 bits), one registered command stage, one read-return stage.
- States: FREE (lock_valid=0), LOCKED0 and LOCKED1 (lock_valid=1, owner 0 or 1).
- FREE arbitration: a single requester is granted. If both request, grant !last_gnt (round-robin). last_gnt updates on every grant.
- LOCKEDn: only rn may be granted. r(1-n)_gnt=0 regardless of req.
- Lock set: an accepted access with rn_lock=1 moves to LOCKEDn. lock_cnt clears on entry.
- Lock release: in any LOCKEDn cycle with rn_lock=0 (req or not), the state is FREE from the next cycle. The same-cycle access by rn is still granted.
- Timeout: in LOCKEDn, lock_cnt increments each cycle the other requester's req=1. At lock_cnt==LOCK_MAX-1 with the other req high, the block forces FREE next cycle, pulses lock_break, and sets last_gnt=n so the other side wins the next tie. The owner's access in that cycle is still granted.
- Accepted access is registered: cs=1, we, address, and data_out (wdata, or 0 on reads) are driven for exactly the next cycle. With no grant, cs=0 and we=0, and address/data_out hold their last values.
- Read return: on a cs=1, we=0 cycle, data_in is sampled into the requester's rdata. rvalid pulses the following cycle.
- Writes produce no rvalid.

## Timing
- Reset values: cs=0, we=0, address=0, data_out=0, r0/r1_rvalid=0, r0/r1_rdata=0, lock_break=0, FREE, last_gnt=1 (r0 wins the first tie), lock_cnt=0.
- Read latency: grant in cycle N, SRAM access in N+1, rvalid/rdata in N+2. Full throughput of one access per cycle, back-to-back, with either port.
- Handshake: a requester holds req/addr/we/wdata/lock stable until gnt=1. gnt depends only on current inputs and registered state.
- Simultaneous lock request by both ports in FREE: the round-robin winner locks, and the loser waits.
- Reset mid-operation: in-flight commands and pending rvalid are discarded. The next cycle shows reset values.
- Addresses wrap naturally within ADDR_WIDTH. No range checking.

## Test plan
- Single read: r0 reads addr 0x05 with SRAM[5]=0xEE. Required: r0_gnt in cycle 0, cs=1, we=0, address=0x05 in cycle 1, r0_rvalid=1 and r0_rdata=0xEE in cycle 2.
- Round-robin: both request reads continuously after reset. Required: grants alternate r0,r1,r0,r1, and each rvalid arrives 2 cycles after its grant.
- Lock burst: r0 writes 0x80..0x83 with lock=1, while r1 requests throughout. Required: r1_gnt=0 during the burst, and r1 is granted in the cycle after r0 drops lock.
- Lock timeout with LOCK_MAX=4: r0 holds lock indefinitely while r1 requests. Required: lock_break pulses after 4 waiting cycles, r1 granted the next cycle, and r0 not relocked before r1 is served.
- Write then read same address: r1 writes 0x3C=0x00, then immediately reads 0x3C. Required: the read returns 0x00, and no rvalid appears for the write.
- Reset during read: assert reset in the cycle cs=1. Required: no rvalid, and all outputs at reset values the next cycle.
